// File: rtl/ctrl_convseq.sv
// Sequencer for a polyphase convolution engine: writes each new sample into a
// ring buffer, then runs PHASE_NUM load/calc/output passes through the RAM driver.
module ctrl_convseq #(
    parameter int ADDR_WIDTH = 12,
    parameter int PHASE_NUM  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    input  logic [ADDR_WIDTH-1:0] data_bptr,
    input  logic [ADDR_WIDTH-1:0] data_lptr,
    input  logic [ADDR_WIDTH-1:0] coef_base,
    input  logic [ADDR_WIDTH-1:0] taps_len,
    input  logic                  conv_pass,
    output logic                  sample_we,
    output logic [ADDR_WIDTH-1:0] sample_waddr,
    output logic [ADDR_WIDTH-1:0] data_hptr,
    output logic [ADDR_WIDTH-1:0] coef_ptr,
    output logic                  en_init,
    output logic                  ringbuf_init,
    output logic                  coeff_load,
    output logic                  en_calc,
    output logic                  ringbuf_addr_clr,
    output logic                  mac_clr,
    output logic                  mac_en,
    output logic                  result_valid,
    output logic [3:0]            result_phase,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        LOAD,
        CALC,
        OUT
    } state_t;

    localparam logic [3:0] LAST_PHASE = 4'(PHASE_NUM - 1);

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            phase;
    logic [ADDR_WIDTH-1:0] nxt;

    // Head wraps back to the segment base once it has reached the last address.
    assign nxt = (data_hptr == data_lptr) ? data_bptr : data_hptr + ADDR_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sample_ready = 1'b0;
        sample_we    = 1'b0;
        sample_waddr = '0;
        en_init      = 1'b0;
        ringbuf_init = 1'b0;
        coeff_load   = 1'b0;
        en_calc      = 1'b0;
        mac_clr      = 1'b0;
        mac_en       = 1'b0;
        result_valid = 1'b0;
        result_phase = 4'd0;
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                // Held low while rst is asserted so nothing is accepted during reset.
                sample_ready = ~rst;
                if (sample_valid) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                sample_we    = 1'b1;
                sample_waddr = nxt;
                state_nxt    = LOAD;
            end
            LOAD: begin
                en_init      = 1'b1;
                ringbuf_init = 1'b1;
                coeff_load   = 1'b1;
                mac_clr      = 1'b1;
                state_nxt    = CALC;
            end
            CALC: begin
                en_calc = 1'b1;
                mac_en  = 1'b1;
                if (conv_pass) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                result_valid = 1'b1;
                result_phase = phase;
                state_nxt    = (phase == LAST_PHASE) ? IDLE : LOAD;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ringbuf_addr_clr <= 1'b0;
        end else begin
            ringbuf_addr_clr <= flush;
        end
    end

    // Flush parks the head on the last address so the next write lands at the base.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_hptr <= data_lptr;
            phase     <= 4'd0;
            coef_ptr  <= '0;
        end else if (flush) begin
            data_hptr <= data_lptr;
            phase     <= 4'd0;
            coef_ptr  <= coef_base;
        end else begin
            case (state)
                WRITE: begin
                    data_hptr <= nxt;
                    phase     <= 4'd0;
                    coef_ptr  <= coef_base;
                end
                OUT: begin
                    if (phase != LAST_PHASE) begin
                        phase    <= phase + 4'd1;
                        coef_ptr <= coef_ptr + taps_len;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_convseq.sv
// Directed bench for ctrl_convseq: a single-phase instance and a four-phase
// instance, with result phases and coefficient pointers checked from queues.
module tb_ctrl_convseq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [11:0] data_bptr = 12'h100;
    logic [11:0] data_lptr = 12'h10F;
    logic [11:0] coef_base = 12'h800;
    logic [11:0] taps_len = 12'h020;

    logic        a_sv = 1'b0, a_cp = 1'b0;
    logic        a_sample_ready, a_sample_we, a_en_init, a_ringbuf_init, a_coeff_load;
    logic        a_en_calc, a_ringbuf_addr_clr, a_mac_clr, a_mac_en, a_result_valid, a_busy;
    logic [11:0] a_sample_waddr, a_data_hptr, a_coef_ptr;
    logic [3:0]  a_result_phase;

    logic        b_sv = 1'b0, b_cp = 1'b0;
    logic        b_sample_ready, b_sample_we, b_en_init, b_ringbuf_init, b_coeff_load;
    logic        b_en_calc, b_ringbuf_addr_clr, b_mac_clr, b_mac_en, b_result_valid, b_busy;
    logic [11:0] b_sample_waddr, b_data_hptr, b_coef_ptr;
    logic [3:0]  b_result_phase;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int a_res_cnt = 0;
    int b_res_cnt = 0;
    logic [11:0] a_exp_h = 12'h10F;
    logic [11:0] b_exp_h = 12'h10F;
    logic [3:0]  a_phase_q[$];
    logic [3:0]  b_phase_q[$];
    logic [11:0] b_coef_q[$];

    always #5 clk = ~clk;

    ctrl_convseq #(.ADDR_WIDTH(12), .PHASE_NUM(1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .sample_valid(a_sv), .sample_ready(a_sample_ready),
        .data_bptr(data_bptr), .data_lptr(data_lptr), .coef_base(coef_base), .taps_len(taps_len),
        .conv_pass(a_cp), .sample_we(a_sample_we), .sample_waddr(a_sample_waddr),
        .data_hptr(a_data_hptr), .coef_ptr(a_coef_ptr), .en_init(a_en_init),
        .ringbuf_init(a_ringbuf_init), .coeff_load(a_coeff_load), .en_calc(a_en_calc),
        .ringbuf_addr_clr(a_ringbuf_addr_clr), .mac_clr(a_mac_clr), .mac_en(a_mac_en),
        .result_valid(a_result_valid), .result_phase(a_result_phase), .busy(a_busy)
    );

    ctrl_convseq #(.ADDR_WIDTH(12), .PHASE_NUM(4)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .sample_valid(b_sv), .sample_ready(b_sample_ready),
        .data_bptr(data_bptr), .data_lptr(data_lptr), .coef_base(coef_base), .taps_len(taps_len),
        .conv_pass(b_cp), .sample_we(b_sample_we), .sample_waddr(b_sample_waddr),
        .data_hptr(b_data_hptr), .coef_ptr(b_coef_ptr), .en_init(b_en_init),
        .ringbuf_init(b_ringbuf_init), .coeff_load(b_coeff_load), .en_calc(b_en_calc),
        .ringbuf_addr_clr(b_ringbuf_addr_clr), .mac_clr(b_mac_clr), .mac_en(b_mac_en),
        .result_valid(b_result_valid), .result_phase(b_result_phase), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then sample outputs and service the scoreboards.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (a_result_valid) begin
            a_res_cnt++;
            if (a_phase_q.size() == 0) chk("a_unexpected_result", a_result_valid, 0);
            else chk("a_result_phase", a_result_phase, a_phase_q.pop_front());
        end
        if (b_result_valid) begin
            b_res_cnt++;
            if (b_phase_q.size() == 0) chk("b_unexpected_result", b_result_valid, 0);
            else chk("b_result_phase", b_result_phase, b_phase_q.pop_front());
        end
        if (b_coeff_load) begin
            if (b_coef_q.size() == 0) chk("b_unexpected_load", b_coeff_load, 0);
            else chk("b_coef_ptr", b_coef_ptr, b_coef_q.pop_front());
        end
        if (a_sample_we) chk("a_waddr_window", (a_sample_waddr >= 12'h100 && a_sample_waddr <= 12'h10F), 1);
        if (b_sample_we) chk("b_waddr_window", (b_sample_waddr >= 12'h100 && b_sample_waddr <= 12'h10F), 1);
    endtask

    // One complete four-phase sample on dut_b with ncalc CALC cycles per phase.
    task automatic b_sample(input int ncalc, input bit strobe);
        int c0;
        logic [11:0] exp_w;
        exp_w = (b_exp_h == 12'h10F) ? 12'h100 : b_exp_h + 12'h001;
        b_exp_h = exp_w;
        for (int p = 0; p < 4; p++) begin
            b_phase_q.push_back(4'(p));
            b_coef_q.push_back(12'h800 + 12'(p * 32));
        end
        b_sv = 1'b1;
        tick();
        b_sv = 1'b0;
        c0 = cyc;
        chk("b_we", b_sample_we, 1);
        chk("b_waddr", b_sample_waddr, exp_w);
        for (int p = 0; p < 4; p++) begin
            tick();
            chk("b_load", b_coeff_load, 1);
            chk("b_ready_load", b_sample_ready, 0);
            if (ncalc == 1) b_cp = 1'b1;
            tick();
            for (int i = 1; i <= ncalc; i++) begin
                chk("b_en_calc", b_en_calc, 1);
                if (strobe && p == 1 && i == 1) b_sv = 1'b1;
                if (i == ncalc) b_cp = 1'b1;
                tick();
                b_sv = 1'b0;
                b_cp = 1'b0;
            end
            chk("b_result_valid", b_result_valid, 1);
            chk("b_ready_out", b_sample_ready, 0);
        end
        chk("b_latency", cyc - c0 + 1, 1 + 4 * (2 + ncalc));
        tick();
        chk("b_hptr", b_data_hptr, exp_w);
        chk("b_idle_ready", b_sample_ready, 1);
    endtask

    initial begin
        int c0;
        int saved;

        // Reset state
        tick();
        tick();
        chk("rst_b_ready", b_sample_ready, 0);
        chk("rst_a_ready", a_sample_ready, 0);
        chk("rst_b_busy", b_busy, 0);
        chk("rst_b_hptr", b_data_hptr, 12'h10F);
        chk("rst_b_coef", b_coef_ptr, 12'h000);
        rst = 1'b0;
        #1;
        chk("rel_a_ready", a_sample_ready, 1);
        chk("rel_b_ready", b_sample_ready, 1);

        // Single-phase run on dut_a, 16 CALC cycles
        a_phase_q.push_back(4'd0);
        a_sv = 1'b1;
        tick();
        a_sv = 1'b0;
        c0 = cyc;
        chk("a_we", a_sample_we, 1);
        chk("a_waddr", a_sample_waddr, 12'h100);
        chk("a_ready_write", a_sample_ready, 0);
        tick();
        chk("a_hptr", a_data_hptr, 12'h100);
        chk("a_load", a_coeff_load, 1);
        chk("a_mac_clr", a_mac_clr, 1);
        tick();
        for (int i = 1; i <= 16; i++) begin
            chk("a_en_calc", a_en_calc, 1);
            if (i == 16) a_cp = 1'b1;
            tick();
        end
        a_cp = 1'b0;
        chk("a_result_valid", a_result_valid, 1);
        chk("a_latency", cyc - c0 + 1, 19);
        tick();
        chk("a_idle_ready", a_sample_ready, 1);
        chk("a_result_count", a_res_cnt, 1);

        // Polyphase stepping, then fill and wrap the ring buffer
        b_sample(3, 1'b0);
        for (int k = 0; k < 16; k++) begin
            if (k == 5) b_sample(4, 1'b1);
            else b_sample(1, 1'b0);
        end
        chk("b_wrap_hptr", b_data_hptr, 12'h100);
        tick();
        chk("b_no_extra_write", b_sample_we, 0);
        chk("b_no_extra_busy", b_busy, 0);

        // Flush at CALC cycle 5
        saved = b_res_cnt;
        b_coef_q.push_back(12'h800);
        b_sv = 1'b1;
        tick();
        b_sv = 1'b0;
        chk("fl_waddr", b_sample_waddr, 12'h101);
        tick();
        tick();
        repeat (4) tick();
        chk("fl_in_calc", b_en_calc, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_busy", b_busy, 0);
        chk("fl_ready", b_sample_ready, 1);
        chk("fl_clr", b_ringbuf_addr_clr, 1);
        chk("fl_hptr", b_data_hptr, 12'h10F);
        chk("fl_coef", b_coef_ptr, 12'h800);
        tick();
        chk("fl_clr_end", b_ringbuf_addr_clr, 0);
        chk("fl_no_result", b_res_cnt, saved);
        b_exp_h = 12'h10F;
        b_sample(2, 1'b0);

        // Flush together with a sample strobe in IDLE drops the sample
        flush = 1'b1;
        b_sv = 1'b1;
        tick();
        flush = 1'b0;
        b_sv = 1'b0;
        chk("fs_busy", b_busy, 0);
        chk("fs_we", b_sample_we, 0);
        chk("fs_clr", b_ringbuf_addr_clr, 1);
        tick();
        chk("fs_busy2", b_busy, 0);
        chk("fs_hptr", b_data_hptr, 12'h10F);
        b_exp_h = 12'h10F;

        // Reset during LOAD, with flush held to confirm reset wins
        saved = b_res_cnt;
        b_coef_q.push_back(12'h800);
        b_sv = 1'b1;
        tick();
        b_sv = 1'b0;
        tick();
        chk("rl_in_load", b_coeff_load, 1);
        rst = 1'b1;
        flush = 1'b1;
        tick();
        chk("rl_ready", b_sample_ready, 0);
        chk("rl_busy", b_busy, 0);
        chk("rl_ctrl", {b_en_init, b_ringbuf_init, b_coeff_load, b_en_calc,
                        b_mac_clr, b_mac_en, b_result_valid, b_sample_we}, 0);
        chk("rl_clr", b_ringbuf_addr_clr, 0);
        chk("rl_hptr", b_data_hptr, 12'h10F);
        chk("rl_coef", b_coef_ptr, 12'h000);
        flush = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("rl_rel_ready", b_sample_ready, 1);
        repeat (8) tick();
        chk("rl_no_result", b_res_cnt, saved);
        chk("rl_hptr_after", b_data_hptr, 12'h10F);
        chk("b_phase_q_empty", b_phase_q.size(), 0);
        chk("b_coef_q_empty", b_coef_q.size(), 0);
        chk("a_phase_q_empty", a_phase_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
